// File: rtl/iref_pkg.sv
// iref_pkg
// Shared definitions for the current-reference ramp controller.
//   CODE_W             width of the charge code
//   IREF_PD_ADDR       power-down register address
//   IREF_CHARGE_ADDR   charge register address
//   iref_state_t       ramp sequencer states
//   iref_next_code()   one ramp step towards the target, clamped so that the
//                      ramp never overshoots or wraps
package iref_pkg;

   localparam int CODE_W           = 8;
   localparam int IREF_PD_ADDR     = 0;
   localparam int IREF_CHARGE_ADDR = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PD_WR,
      ST_CH_WR,
      ST_DWELL,
      ST_FIN
   } iref_state_t;

   // One extra bit catches both the carry out of cur + step and the borrow
   // out of cur - step; either case clamps to the target.
   function automatic logic [CODE_W-1:0] iref_next_code(
      input logic [CODE_W-1:0] cur,
      input logic [CODE_W-1:0] tgt,
      input logic [CODE_W-1:0] stp
   );
      logic [CODE_W:0] sum;
      logic [CODE_W:0] diff;
      sum  = {1'b0, cur} + {1'b0, stp};
      diff = {1'b0, cur} - {1'b0, stp};
      if (cur < tgt) begin
         return (sum > {1'b0, tgt}) ? tgt : sum[CODE_W-1:0];
      end else if (cur > tgt) begin
         return (diff[CODE_W] || (diff[CODE_W-1:0] < tgt)) ? tgt : diff[CODE_W-1:0];
      end
      return tgt;
   endfunction

endpackage

// File: rtl/iref_bus_master.sv
// iref_bus_master
// Single-outstanding write request holder for the current-reference bus.
// A load captures address/data and raises m_valid; the request is held
// stable until the edge where m_valid && m_ready, then dropped.
//   clk, rst         clock, asynchronous active-low reset
//   load             capture a new request (ignored while one is pending)
//   load_address     address for the new request
//   load_wdata       write data for the new request
//   m_valid          request pending
//   m_address        request address
//   m_wdata          request write data
//   m_wstrb          write strobe, mirrors m_valid
//   m_ready          responder acknowledge
//   ack              handshake this cycle (m_valid && m_ready)
module iref_bus_master #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_address,
   input  logic [DATA_W-1:0] load_wdata,
   output logic              m_valid,
   output logic [ADDR_W-1:0] m_address,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_wstrb,
   input  logic              m_ready,
   output logic              ack
);

   logic              valid_reg;
   logic [ADDR_W-1:0] address_reg;
   logic [DATA_W-1:0] wdata_reg;

   assign ack = valid_reg & m_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_reg   <= 1'b0;
         address_reg <= '0;
         wdata_reg   <= '0;
      end else if (ack) begin
         // Dropping valid here guarantees one idle cycle between requests.
         valid_reg <= 1'b0;
      end else if (load && !valid_reg) begin
         valid_reg   <= 1'b1;
         address_reg <= load_address;
         wdata_reg   <= load_wdata;
      end
   end

   assign m_valid   = valid_reg;
   assign m_address = address_reg;
   assign m_wdata   = wdata_reg;
   assign m_wstrb   = valid_reg;

endmodule

// File: rtl/iref_ramp_ctrl.sv
// iref_ramp_ctrl
// Ramps the current-reference charge code from its present value to a
// target: one power-down release write, then charge writes in steps of
// `step`, each followed by `dwell` idle cycles.
//   clk, rst          clock, asynchronous active-low reset
//   start             one-cycle request, accepted only in IDLE without abort
//   abort             level; stops the ramp at the next safe point
//   target/step/dwell ramp parameters, latched on accepted start
//   busy              ramp in progress
//   done              one-cycle pulse on normal completion
//   cur_code          last charge code acknowledged by the responder
//   m_valid/m_address/m_wdata/m_wstrb/m_ready  responder write bus
module iref_ramp_ctrl
   import iref_pkg::*;
#(
   parameter int IREF_ADDR_W = 2,
   parameter int DATA_W      = 32,
   parameter int DWELL_W     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [CODE_W-1:0]      target,
   input  logic [CODE_W-1:0]      step,
   input  logic [DWELL_W-1:0]     dwell,
   output logic                   busy,
   output logic                   done,
   output logic [CODE_W-1:0]      cur_code,
   output logic                   m_valid,
   output logic [IREF_ADDR_W-1:0] m_address,
   output logic [DATA_W-1:0]      m_wdata,
   output logic                   m_wstrb,
   input  logic                   m_ready
);

   localparam logic [IREF_ADDR_W-1:0] PD_ADDR     = IREF_ADDR_W'(IREF_PD_ADDR);
   localparam logic [IREF_ADDR_W-1:0] CHARGE_ADDR = IREF_ADDR_W'(IREF_CHARGE_ADDR);

   iref_state_t        state_reg, state_next;
   logic [CODE_W-1:0]  code_reg, code_next;
   logic [CODE_W-1:0]  target_reg, target_next;
   logic [CODE_W-1:0]  step_reg, step_next;
   logic [DWELL_W-1:0] dwell_reg, dwell_next;
   logic [DWELL_W-1:0] cnt_reg, cnt_next;

   logic                   load;
   logic [IREF_ADDR_W-1:0] load_address;
   logic [DATA_W-1:0]      load_wdata;
   logic                   ack;
   logic [CODE_W-1:0]      next_code;
   logic [DATA_W-1:0]      charge_word;

   assign next_code = iref_next_code(code_reg, target_reg, step_reg);

   // Charge code in the low bits of the write word, upper bits zero.
   genvar gi;
   generate
      for (gi = 0; gi < DATA_W; gi++) begin : g_wdata
         if (gi < CODE_W) begin : g_code
            assign charge_word[gi] = next_code[gi];
         end else begin : g_zero
            assign charge_word[gi] = 1'b0;
         end
      end
   endgenerate

   iref_bus_master #(
      .ADDR_W (IREF_ADDR_W),
      .DATA_W (DATA_W)
   ) u_bus (
      .clk          (clk),
      .rst          (rst),
      .load         (load),
      .load_address (load_address),
      .load_wdata   (load_wdata),
      .m_valid      (m_valid),
      .m_address    (m_address),
      .m_wdata      (m_wdata),
      .m_wstrb      (m_wstrb),
      .m_ready      (m_ready),
      .ack          (ack)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= ST_IDLE;
         code_reg   <= '0;
         target_reg <= '0;
         step_reg   <= CODE_W'(1);
         dwell_reg  <= '0;
         cnt_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         code_reg   <= code_next;
         target_reg <= target_next;
         step_reg   <= step_next;
         dwell_reg  <= dwell_next;
         cnt_reg    <= cnt_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      code_next    = code_reg;
      target_next  = target_reg;
      step_next    = step_reg;
      dwell_next   = dwell_reg;
      cnt_next     = cnt_reg;
      load         = 1'b0;
      load_address = PD_ADDR;
      load_wdata   = '0;

      case (state_reg)
         ST_IDLE: begin
            // The power-up write is issued on the accepting edge so that
            // busy and m_valid rise together.
            if (start && !abort) begin
               target_next = target;
               step_next   = (step == '0) ? CODE_W'(1) : step;
               dwell_next  = dwell;
               load        = 1'b1;
               state_next  = ST_PD_WR;
            end
         end

         ST_PD_WR: begin
            if (ack) begin
               if (abort)                       state_next = ST_IDLE;
               else if (code_reg == target_reg) state_next = ST_FIN;
               else                             state_next = ST_CH_WR;
            end
         end

         ST_CH_WR: begin
            if (!m_valid) begin
               // Idle slot between requests: the only point where abort
               // can cancel a charge write before it is issued.
               if (abort) begin
                  state_next = ST_IDLE;
               end else begin
                  load         = 1'b1;
                  load_address = CHARGE_ADDR;
                  load_wdata   = charge_word;
               end
            end else if (ack) begin
               // code_reg is unchanged while the request is pending, so
               // next_code still equals the value being written.
               code_next = next_code;
               if (abort) begin
                  state_next = ST_IDLE;
               end else if (dwell_reg == '0) begin
                  state_next = (next_code == target_reg) ? ST_FIN : ST_CH_WR;
               end else begin
                  cnt_next   = dwell_reg - DWELL_W'(1);
                  state_next = ST_DWELL;
               end
            end
         end

         ST_DWELL: begin
            if (abort) begin
               state_next = ST_IDLE;
            end else if (cnt_reg != '0) begin
               cnt_next = cnt_reg - DWELL_W'(1);
            end else if (code_reg == target_reg) begin
               state_next = ST_FIN;
            end else begin
               // Issue the next write as the dwell expires so the bus sees
               // exactly `dwell` idle cycles.
               load         = 1'b1;
               load_address = CHARGE_ADDR;
               load_wdata   = charge_word;
               state_next   = ST_CH_WR;
            end
         end

         ST_FIN: begin
            state_next = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign busy     = (state_reg != ST_IDLE);
   assign done     = (state_reg == ST_FIN);
   assign cur_code = code_reg;

endmodule
